mmio_bus_arbiter: RTL and testbench



---
 rtl/mmio_bus_pkg.sv | 24 ++
 rtl/mmio_addr_decode.sv | 33 +++
 rtl/mmio_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bus_pkg.sv
// Shared types and default address map for the MMIO bus controller.
//   state_e  : controller FSM states
//   region_e : decoded slave region of a byte address
//   *Default : default inclusive byte-address bounds of BRAM and GPIO
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RegNone = 2'd0,
    RegBram = 2'd1,
    RegGpio = 2'd2
  } region_e;

  localparam logic [31:0] BramBaseDefault = 32'h0000_0000;
  localparam logic [31:0] BramTopDefault  = 32'h0000_07FF;
  localparam logic [31:0] GpioBaseDefault = 32'hFFFF_FFF0;
  localparam logic [31:0] GpioTopDefault  = 32'hFFFF_FFF3;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational byte-address to slave-region decoder (inclusive, unsigned bounds).
// Ports:
//   addr_i   : 32-bit byte address
//   region_o : RegBram, RegGpio or RegNone
module mmio_addr_decode
  import mmio_bus_pkg::*;
#(
  parameter logic [31:0] BramBase = BramBaseDefault,
  parameter logic [31:0] BramTop  = BramTopDefault,
  parameter logic [31:0] GpioBase = GpioBaseDefault,
  parameter logic [31:0] GpioTop  = GpioTopDefault
) (
  input  logic [31:0] addr_i,
  output region_e     region_o
);

  logic in_bram;
  logic in_gpio;

  // Offset compare: one unsigned test checks both bounds and stays meaningful with a zero base.
  assign in_bram = (addr_i - BramBase) <= (BramTop - BramBase);
  assign in_gpio = (addr_i - GpioBase) <= (GpioTop - GpioBase);

  always_comb begin
    region_o = RegNone;
    if (in_bram) begin
      region_o = RegBram;
    end else if (in_gpio) begin
      region_o = RegGpio;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master / two-slave MMIO bus controller.
// Accepts one request at a time (IDLE), drives the slave bus for one cycle (ACCESS) and, for
// reads, returns the slave data one cycle later (RESP) selected by the registered region.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   mN_valid/we/addr/wdata/mask : master N request (held until mN_ready)
//   mN_ready                  : request accepted this cycle
//   mN_rvalid, mN_rdata       : read response pulse and data
//   bus_addr/wdata/mask       : shared slave bus, held between transactions
//   bram_we, gpio_we          : one-cycle write strobes
//   bram_rdata, gpio_rdata    : slave read data, one cycle after the address
// Build option: define MMIO_ARB_RR_EN for round-robin arbitration (default: m0 fixed priority).
module mmio_bus_arbiter
  import mmio_bus_pkg::*;
#(
  parameter logic [31:0] BRAM_BASE = BramBaseDefault,
  parameter logic [31:0] BRAM_TOP  = BramTopDefault,
  parameter logic [31:0] GPIO_BASE = GpioBaseDefault,
  parameter logic [31:0] GPIO_TOP  = GpioTopDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_mask,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_mask,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  output logic        bram_we,
  output logic        gpio_we,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] gpio_rdata
);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        we_q, we_d;
  region_e     region_q, region_d;

  logic        grant1;
  logic [31:0] req_addr;
  region_e     req_region;
  logic [31:0] resp_data;

`ifdef MMIO_ARB_RR_EN
  // 1 = m1 was granted last; resets to 1 so m0 wins the first tie.
  logic last_grant_q, last_grant_d;
  assign grant1 = m1_valid & (~m0_valid | ~last_grant_q);
`else
  assign grant1 = m1_valid & ~m0_valid;
`endif

  assign req_addr = grant1 ? m1_addr : m0_addr;

  mmio_addr_decode #(
    .BramBase (BRAM_BASE),
    .BramTop  (BRAM_TOP),
    .GpioBase (GPIO_BASE),
    .GpioTop  (GPIO_TOP)
  ) u_decode (
    .addr_i   (req_addr),
    .region_o (req_region)
  );

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_mask  = mask_q;

  always_comb begin
    unique case (region_q)
      RegBram: resp_data = bram_rdata;
      RegGpio: resp_data = gpio_rdata;
      default: resp_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    we_d      = we_q;
    region_d  = region_q;
`ifdef MMIO_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    bram_we   = 1'b0;
    gpio_we   = 1'b0;

    // Handshakes and strobes are suppressed while reset is held so nothing issues mid-reset.
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (m0_valid || m1_valid) begin
            m0_ready = ~grant1;
            m1_ready = grant1;
            owner_d  = grant1;
            addr_d   = req_addr;
            wdata_d  = grant1 ? m1_wdata : m0_wdata;
            mask_d   = grant1 ? m1_mask : m0_mask;
            we_d     = grant1 ? m1_we : m0_we;
            region_d = req_region;
            state_d  = StAccess;
`ifdef MMIO_ARB_RR_EN
            last_grant_d = grant1;
`endif
          end
        end
        StAccess: begin
          bram_we = we_q && (region_q == RegBram);
          gpio_we = we_q && (region_q == RegGpio);
          state_d = we_q ? StIdle : StResp;
        end
        StResp: begin
          m0_rvalid = ~owner_q;
          m1_rvalid = owner_q;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign m0_rdata = m0_rvalid ? resp_data : 32'h0;
  assign m1_rdata = m1_rvalid ? resp_data : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      mask_q   <= 4'h0;
      we_q     <= 1'b0;
      region_q <= RegNone;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      we_q     <= we_d;
      region_q <= region_d;
    end
  end

`ifdef MMIO_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: directed cases with literal expectations, then
// randomized traffic against a transaction-level reference model.
module tb_mmio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_we, m0_ready, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_mask;
  logic        m1_valid, m1_we, m1_ready, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_mask;
  logic [31:0] bus_addr, bus_wdata, bram_rdata, gpio_rdata;
  logic [3:0]  bus_mask;
  logic        bram_we, gpio_we;

  always #5 clk = ~clk;

  mmio_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_valid   (m0_valid),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_mask    (m0_mask),
    .m0_ready   (m0_ready),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_mask    (m1_mask),
    .m1_ready   (m1_ready),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_mask   (bus_mask),
    .bram_we    (bram_we),
    .gpio_we    (gpio_we),
    .bram_rdata (bram_rdata),
    .gpio_rdata (gpio_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Slave models: BRAM and one GPIO word, both with one-cycle registered read data.
  bit [31:0] mem [512];
  bit [31:0] gpio_reg;
  always @(posedge clk) begin
    if (bram_we) mem[bus_addr[10:2]] <= merge(mem[bus_addr[10:2]], bus_wdata, bus_mask);
    if (gpio_we) gpio_reg <= merge(gpio_reg, bus_wdata, bus_mask);
    bram_rdata <= mem[bus_addr[10:2]];
    gpio_rdata <= gpio_reg;
  end

  // Reference model: the in-flight transaction and how many cycles it has been in service.
  typedef enum {RNone, RBram, RGpio} rgn_t;
  typedef struct {
    int          owner;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    rgn_t        rgn;
  } txn_t;

  function automatic rgn_t region_of(input logic [31:0] a);
    if (a <= 32'h0000_07FF) return RBram;
    if (a >= 32'hFFFF_FFF0 && a <= 32'hFFFF_FFF3) return RGpio;
    return RNone;
  endfunction

  bit [31:0]   ref_mem [512];
  bit [31:0]   ref_gpio;
  txn_t        cur;
  int          busy = 0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_mask = 4'h0;
  int          last_owner = 1;
  bit          armed = 1'b0;

  always @(negedge clk) begin : model
    logic        e_r0, e_r1, e_v0, e_v1, e_bwe, e_gwe;
    logic [31:0] e_rd;
    int          win;
    e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; e_bwe = 0; e_gwe = 0; e_rd = 32'h0; win = -1;
    if (!reset) begin
      if (busy == 0) begin
        if (m0_valid && m1_valid) begin
`ifdef MMIO_ARB_RR_EN
          win = (last_owner == 1) ? 0 : 1;
`else
          win = 0;
`endif
        end else if (m0_valid) win = 0;
        else if (m1_valid) win = 1;
        e_r0 = (win == 0);
        e_r1 = (win == 1);
      end else if (busy == 1) begin
        e_bwe = cur.we && cur.rgn == RBram;
        e_gwe = cur.we && cur.rgn == RGpio;
      end else begin
        e_v0 = (cur.owner == 0);
        e_v1 = (cur.owner == 1);
        if (cur.rgn == RBram) e_rd = ref_mem[cur.addr[10:2]];
        else if (cur.rgn == RGpio) e_rd = ref_gpio;
      end
    end
    if (armed) begin
      chk("m0_ready", m0_ready, e_r0);
      chk("m1_ready", m1_ready, e_r1);
      chk("m0_rvalid", m0_rvalid, e_v0);
      chk("m1_rvalid", m1_rvalid, e_v1);
      chk("bram_we", bram_we, e_bwe);
      chk("gpio_we", gpio_we, e_gwe);
      chk("bus_addr", bus_addr, last_addr);
      chk("bus_wdata", bus_wdata, last_wdata);
      chk("bus_mask", bus_mask, last_mask);
      if (e_v0) chk("m0_rdata", m0_rdata, e_rd);
      if (e_v1) chk("m1_rdata", m1_rdata, e_rd);
    end
    // Advance to the state after the coming posedge.
    if (reset) begin
      busy = 0; last_addr = 0; last_wdata = 0; last_mask = 0; last_owner = 1;
    end else if (busy == 0 && win >= 0) begin
      cur.owner = win;
      cur.we    = (win == 0) ? m0_we : m1_we;
      cur.addr  = (win == 0) ? m0_addr : m1_addr;
      cur.wdata = (win == 0) ? m0_wdata : m1_wdata;
      cur.mask  = (win == 0) ? m0_mask : m1_mask;
      cur.rgn   = region_of(cur.addr);
      last_addr = cur.addr; last_wdata = cur.wdata; last_mask = cur.mask; last_owner = win;
      busy = 1;
    end else if (busy == 1) begin
      if (cur.we && cur.rgn == RBram)
        ref_mem[cur.addr[10:2]] = merge(ref_mem[cur.addr[10:2]], cur.wdata, cur.mask);
      if (cur.we && cur.rgn == RGpio) ref_gpio = merge(ref_gpio, cur.wdata, cur.mask);
      busy = cur.we ? 0 : 2;
    end else if (busy == 2) begin
      busy = 0;
    end
  end

  // Stimulus helpers: step() samples at negedge, then drops any accepted valid after the edge.
  logic        s_r0, s_r1, s_v0, s_v1, s_b, s_g;
  logic [31:0] s_d0, s_d1, s_ba;
  logic [3:0]  s_bm;

  task automatic step();
    @(negedge clk);
    s_r0 = m0_ready; s_r1 = m1_ready; s_v0 = m0_rvalid; s_v1 = m1_rvalid;
    s_d0 = m0_rdata; s_d1 = m1_rdata; s_b = bram_we; s_g = gpio_we;
    s_ba = bus_addr; s_bm = bus_mask;
    @(posedge clk);
    #1;
    if (s_r0) m0_valid = 1'b0;
    if (s_r1) m1_valid = 1'b0;
  endtask

  task automatic issue(input int m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    if (m == 0) begin
      m0_valid = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_mask = mask;
    end else begin
      m1_valid = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_mask = mask;
    end
  endtask

  task automatic run_txn(input int m, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output int acc, output int done, output bit sb, output bit sg);
    acc = -1; done = -1; sb = 0; sg = 0; rd = 32'h0;
    issue(m, we, addr, wdata, 4'hF);
    for (int c = 1; c <= 30 && done < 0; c++) begin
      step();
      if (((m == 0) ? s_r0 : s_r1) && acc < 0) acc = c;
      if (s_b) sb = 1;
      if (s_g) sg = 1;
      if (we && acc > 0 && c == acc + 1) done = c;
      if (!we && ((m == 0) ? s_v0 : s_v1)) begin
        done = c;
        rd = (m == 0) ? s_d0 : s_d1;
      end
    end
    chk("txn_completed", 32'(done > 0), 32'h1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0, 1:    return {21'h0, 11'($urandom_range(0, 2047))};
      2:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3));
      3:       return 32'h0000_0800 + 32'($urandom_range(0, 3));
      default: return 32'hFFFF_FFEC + 32'($urandom_range(0, 12));
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    int          acc, done;
    bit          sb, sg;
    reset = 1; m0_valid = 0; m1_valid = 0;
    m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_mask = 0;
    m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_mask = 0;
    @(posedge clk); #1;
    armed = 1;
    m0_valid = 1;  // must not be accepted while reset is held
    step();
    chk("rst_m0_ready", s_r0, 0);
    chk("rst_bus_addr", s_ba, 0);
    m0_valid = 0;
    reset = 0;
    step();

    // Write then read BRAM 0x10.
    run_txn(0, 1, 32'h10, 32'hA5A5_1234, rd, acc, done, sb, sg);
    chk("w_accept_cycle", acc, 1);
    chk("w_done_cycle", done, 2);
    chk("w_bram_we", sb, 1);
    chk("w_gpio_we", sg, 0);
    run_txn(0, 0, 32'h10, 32'h0, rd, acc, done, sb, sg);
    chk("r_rvalid_cycle", done, 3);
    chk("r_data", rd, 32'hA5A5_1234);

    // Simultaneous reads; m0 re-requests straight after being accepted.
    issue(0, 0, 32'h10, 0, 4'hF);
    issue(1, 0, 32'h14, 0, 4'hF);
    step();
    chk("tie_m0_ready", s_r0, 1);
    chk("tie_m1_ready", s_r1, 0);
    issue(0, 0, 32'h10, 0, 4'hF);
    step();
    step();
    chk("tie_m0_rvalid", s_v0, 1);
    step();
`ifdef MMIO_ARB_RR_EN
    chk("tie2_m1_first", s_r1, 1);
    chk("tie2_m0_waits", s_r0, 0);
`else
    chk("tie2_m0_first", s_r0, 1);
    chk("tie2_m1_waits", s_r1, 0);
`endif
    repeat (8) step();

    // GPIO write and read back by m1.
    run_txn(1, 1, 32'hFFFF_FFF0, 32'h1, rd, acc, done, sb, sg);
    chk("gpio_w_strobe", sg, 1);
    chk("gpio_w_no_bram", sb, 0);
    run_txn(1, 0, 32'hFFFF_FFF0, 32'h0, rd, acc, done, sb, sg);
    chk("gpio_r_data", rd, 32'h1);

    // Unmapped accesses.
    run_txn(0, 0, 32'h0000_0800, 0, rd, acc, done, sb, sg);
    chk("unm_r800_data", rd, 0);
    chk("unm_r800_cycle", done, 3);
    run_txn(0, 0, 32'hFFFF_FFEC, 0, rd, acc, done, sb, sg);
    chk("unm_rffec_data", rd, 0);
    run_txn(0, 1, 32'h0000_0800, 32'hDEAD_BEEF, rd, acc, done, sb, sg);
    chk("unm_w_strobes", {sb, sg}, 0);
    chk("unm_w_done", done, 2);

    // Region boundaries.
    run_txn(0, 1, 32'h0000_07FF, 32'h1122_3344, rd, acc, done, sb, sg);
    chk("bnd_7ff_bram", {sb, sg}, 32'h2);
    run_txn(1, 1, 32'hFFFF_FFF3, 32'h2, rd, acc, done, sb, sg);
    chk("bnd_fff3_gpio", {sb, sg}, 32'h1);
    run_txn(1, 1, 32'hFFFF_FFF4, 32'h3, rd, acc, done, sb, sg);
    chk("bnd_fff4_none", {sb, sg}, 0);
    run_txn(0, 0, 32'hFFFF_FFF3, 0, rd, acc, done, sb, sg);
    chk("bnd_gpio_rd", rd, 32'h2);

    // Reset during the response cycle of a read.
    issue(0, 0, 32'h10, 0, 4'hF);
    step();
    step();
    reset = 1;
    step();
    chk("rst_resp_no_rvalid", s_v0, 0);
    reset = 0;
    step();
    chk("post_rst_bus_addr", s_ba, 0);
    chk("post_rst_bus_mask", s_bm, 0);
    chk("post_rst_rvalid", s_v0, 0);
    run_txn(0, 0, 32'h10, 0, rd, acc, done, sb, sg);
    chk("post_rst_rd", rd, 32'hA5A5_1234);
    chk("post_rst_cycle", done, 3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!m0_valid && $urandom_range(0, 2) == 0)
        issue(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
      if (!m1_valid && $urandom_range(0, 2) == 0)
        issue(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
